// File: rtl/mod_arith_pkg.sv
// Shared modular-arithmetic constants and operand type for the lattice datapath.
package mod_arith_pkg;

   localparam int Q_W = 23;

   typedef logic [Q_W-1:0] operand_t;

   localparam operand_t Q_DIL = 23'd8380417;

endpackage

// File: rtl/subtractor_n.sv
// Unsigned nb_bit-wide subtractor; borrow_o is high when b_i > a_i.
module subtractor_n
   import mod_arith_pkg::*;
#(
   parameter int nb_bit = Q_W + 1
) (
   input  logic [nb_bit-1:0] a_i,
   input  logic [nb_bit-1:0] b_i,
   output logic [nb_bit-1:0] diff_o,
   output logic              borrow_o
);

   logic [nb_bit:0] full_diff;

   assign full_diff = {1'b0, a_i} - {1'b0, b_i};
   assign diff_o    = full_diff[nb_bit-1:0];
   assign borrow_o  = full_diff[nb_bit];

endmodule

// File: rtl/mod_sub_pipe.sv
// Two-stage valid/ready modular subtractor c = (a - b) mod q.
// Define MOD_SUB_RANGE_CHK_EN to add err_o flagging out-of-range operands.
module mod_sub_pipe
   import mod_arith_pkg::*;
#(
   parameter int W = Q_W
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic [W-1:0] q_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
`ifdef MOD_SUB_RANGE_CHK_EN
   output logic         err_o,
`endif
   output logic [W-1:0] c_o
);

   logic         s1_vld_q, s2_vld_q;
   logic         adv1, adv2, ld1, ld2;
   logic [W:0]   sub_diff;
   logic         sub_borrow;
   logic         unused_sub_msb;
   logic [W:0]   s1_diff_d, s1_diff_q;
   logic [W-1:0] s1_mod_q;
   logic [W-1:0] c_d, c_q;

   // Stage 2 frees up whenever it is empty or its result is taken this cycle.
   assign adv2       = ~s2_vld_q | out_ready_i;
   assign adv1       = ~s1_vld_q | adv2;
   assign ld1        = adv1 & in_valid_i;
   assign ld2        = adv2 & s1_vld_q;
   assign in_ready_o = adv1;

   subtractor_n #(
      .nb_bit (W + 1)
   ) u_sub (
      .a_i      ({1'b0, a_i}),
      .b_i      ({1'b0, b_i}),
      .diff_o   (sub_diff),
      .borrow_o (sub_borrow)
   );

   assign unused_sub_msb = sub_diff[W];
   assign s1_diff_d      = {sub_borrow, sub_diff[W-1:0]};

   // stage 1: raw difference with borrow, plus the modulus it belongs to
   always_ff @(posedge clk_i) begin
      if (ld1) begin
         s1_diff_q <= s1_diff_d;
         s1_mod_q  <= q_i;
      end
   end

   // stage 2: add q back when the subtraction borrowed, truncated to W bits
   always_comb begin
      c_d = s1_diff_q[W-1:0];
      if (s1_diff_q[W]) c_d = s1_diff_q[W-1:0] + s1_mod_q;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         s1_vld_q <= 1'b0;
         s2_vld_q <= 1'b0;
         c_q      <= '0;
      end else begin
         if (adv1) s1_vld_q <= in_valid_i;
         if (adv2) s2_vld_q <= s1_vld_q;
         if (ld2)  c_q      <= c_d;
      end
   end

`ifdef MOD_SUB_RANGE_CHK_EN
   logic s1_err_d, s1_err_q, s2_err_q;

   assign s1_err_d = (a_i >= q_i) | (b_i >= q_i);

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         s1_err_q <= 1'b0;
         s2_err_q <= 1'b0;
      end else begin
         if (ld1) s1_err_q <= s1_err_d;
         if (ld2) s2_err_q <= s1_err_q;
      end
   end

   assign err_o = s2_err_q;
`endif

   assign out_valid_o = s2_vld_q;
   assign c_o         = c_q;

endmodule

// File: tb/tb_mod_sub_pipe.sv
// Scoreboard bench for mod_sub_pipe: randomized and directed operand sets checked
// against an arithmetic (a - b) mod q reference.
module tb_mod_sub_pipe;
   import mod_arith_pkg::*;

   localparam int W = Q_W;

   typedef struct {
      logic [W-1:0] c;
      logic         err;
      logic         chk_c;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_ni;
   logic         in_valid_i, in_ready_o;
   logic [W-1:0] a_i, b_i, q_i;
   logic         out_valid_o, out_ready_i;
   logic [W-1:0] c_o;
`ifdef MOD_SUB_RANGE_CHK_EN
   logic         err_o;
`endif

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   mod_sub_pipe #(.W(W)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .a_i         (a_i),
      .b_i         (b_i),
      .q_i         (q_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
`ifdef MOD_SUB_RANGE_CHK_EN
      .err_o       (err_o),
`endif
      .c_o         (c_o)
   );

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [W-1:0] q);
      longint d;
      exp_t   e;
      d = (longint'(a) - longint'(b)) % longint'(q);
      if (d < 0) d = d + longint'(q);
      e.c     = W'(d);
      e.err   = (a >= q) || (b >= q);
      e.chk_c = !e.err;
      return e;
   endfunction

   task automatic check(input string nm, input logic [W-1:0] got, input logic [W-1:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, got, want);
      end
   endtask

   // one clock of stimulus; acc reports whether the set was taken at this edge
   task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] q, input logic rdy, output logic acc);
      @(posedge clk); #1;
      in_valid_i  = v;
      a_i         = a;
      b_i         = b;
      q_i         = q;
      out_ready_i = rdy;
      @(negedge clk);
      acc = rst_ni && v && in_ready_o;
      if (acc) exp_q.push_back(model(a, b, q));
   endtask

   task automatic idle(input logic rdy);
      logic acc;
      drive(1'b0, '0, '0, Q_DIL, rdy, acc);
   endtask

   // monitor: pops the scoreboard on every output transfer, checks hold while stalled
   logic         stall_prev = 1'b0;
   logic [W-1:0] stall_c;
   always @(negedge clk) begin
      exp_t e;
      if (!rst_ni) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            n_cmp++;
            if (!out_valid_o || c_o !== stall_c) begin
               n_bad++;
               $display("FAIL hold: valid %0b c %0d, expected valid 1 c %0d", out_valid_o, c_o, stall_c);
            end
         end
         if (out_valid_o && out_ready_i) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_result: c %0d, expected no result", c_o);
            end else begin
               e = exp_q.pop_front();
               if (e.chk_c && c_o !== e.c) begin
                  n_bad++;
                  $display("FAIL result: c %0d, expected %0d", c_o, e.c);
               end
`ifdef MOD_SUB_RANGE_CHK_EN
               if (err_o !== e.err) begin
                  n_bad++;
                  $display("FAIL err_flag: err %0b, expected %0b", err_o, e.err);
               end
`endif
            end
         end
         stall_prev = out_valid_o && !out_ready_i;
         stall_c    = c_o;
      end
   end

   initial begin
      logic         acc;
      int           n_acc;
      logic [W-1:0] q, a, b;
      rst_ni = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
      a_i = '0; b_i = '0; q_i = Q_DIL;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", W'(out_valid_o), W'(1'b0));
      check("rst_in_ready", W'(in_ready_o), W'(1'b1));
      check("rst_c", c_o, '0);
      @(posedge clk); #1; rst_ni = 1'b1;

      // latency: a=5,b=3 appears two edges after the accepting negedge sample
      drive(1'b1, 23'd5, 23'd3, Q_DIL, 1'b1, acc);
      check("lat_accept", W'(acc), W'(1'b1));
      idle(1'b1);
      check("lat_not_yet", W'(out_valid_o), W'(1'b0));
      idle(1'b1);
      check("lat_valid", W'(out_valid_o), W'(1'b1));
      check("lat_c", c_o, 23'd2);

      drive(1'b1, 23'd3, 23'd5, Q_DIL, 1'b1, acc);
      drive(1'b1, 23'd0, 23'd8380416, Q_DIL, 1'b1, acc);
      drive(1'b1, 23'd1234, 23'd1234, Q_DIL, 1'b1, acc);
      drive(1'b1, 23'd8380416, 23'd0, Q_DIL, 1'b1, acc);
      repeat (3) idle(1'b1);

      // six back-to-back sets stream out on consecutive cycles
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, W'($urandom_range(0, 8380416)), W'($urandom_range(0, 8380416)), Q_DIL, 1'b1, acc);
         check("b2b_accept", W'(acc), W'(1'b1));
         if (i >= 2) check("b2b_stream", W'(out_valid_o), W'(1'b1));
      end
      idle(1'b1); check("b2b_stream", W'(out_valid_o), W'(1'b1));
      idle(1'b1); check("b2b_stream", W'(out_valid_o), W'(1'b1));
      idle(1'b1); check("b2b_done", W'(out_valid_o), W'(1'b0));

      // stall: only two sets fit, then one is accepted as soon as downstream drains
      n_acc = 0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, W'(100 + i), W'(7 * i), Q_DIL, 1'b0, acc);
         if (acc) n_acc++;
      end
      check("stall_count", W'(n_acc), W'(2));
      check("stall_in_ready", W'(in_ready_o), W'(1'b0));
      idle(1'b0);
      drive(1'b1, 23'd2, 23'd9, Q_DIL, 1'b1, acc);
      check("unstall_accept", W'(acc), W'(1'b1));
      repeat (4) idle(1'b1);

      // reset with two sets in flight discards them
      drive(1'b1, 23'd11, 23'd1, Q_DIL, 1'b0, acc);
      drive(1'b1, 23'd12, 23'd1, Q_DIL, 1'b0, acc);
      @(posedge clk); #1;
      rst_ni = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
      exp_q.delete();
      @(posedge clk); #1; rst_ni = 1'b1;
      @(negedge clk);
      check("rstmid_out_valid", W'(out_valid_o), W'(1'b0));
      check("rstmid_in_ready", W'(in_ready_o), W'(1'b1));
      for (int i = 0; i < 3; i++) begin
         idle(1'b1);
         check("rstmid_no_stale", W'(out_valid_o), W'(1'b0));
      end

`ifdef MOD_SUB_RANGE_CHK_EN
      drive(1'b1, 23'd8380417, 23'd0, Q_DIL, 1'b1, acc);
      drive(1'b1, 23'd17, 23'd4, Q_DIL, 1'b1, acc);
      repeat (3) idle(1'b1);
`endif

      // randomized traffic with random back-pressure and moduli
      for (int i = 0; i < 600; i++) begin
         case ($urandom_range(0, 3))
            0:       q = Q_DIL;
            1:       q = 23'd2;
            default: q = W'($urandom_range(2, 8388607));
         endcase
         case ($urandom_range(0, 3))
            0:       a = '0;
            1:       a = q - 1'b1;
            default: a = W'($urandom_range(0, int'(q) - 1));
         endcase
         case ($urandom_range(0, 3))
            0:       b = '0;
            1:       b = q - 1'b1;
            default: b = W'($urandom_range(0, int'(q) - 1));
         endcase
         drive($urandom_range(0, 9) < 7, a, b, q, $urandom_range(0, 9) < 6, acc);
      end

      for (int i = 0; i < 50 && exp_q.size() != 0; i++) idle(1'b1);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end

endmodule
